// File: rtl/exec_pkg.sv
// Shared definitions for the execute cluster: opcodes, lane state encoding and
// the single-cycle ALU evaluated at full package width and masked down to xlen.
package exec_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FULL = 2'd2
    } lane_state_e;

    // Operands arrive zero-extended; signed ops re-extend from bit xlen-1.
    // MUL and unknown codes yield 0 here (MUL is produced by the lane iterator).
    function automatic logic [XLEN_MAX-1:0] alu_compute(
        input logic [3:0]          op,
        input logic [XLEN_MAX-1:0] a,
        input logic [XLEN_MAX-1:0] b,
        input int                  xlen
    );
        logic [XLEN_MAX-1:0] mask;
        logic [XLEN_MAX-1:0] sa;
        logic [XLEN_MAX-1:0] sb;
        logic [XLEN_MAX-1:0] res;
        logic [5:0]          sh;
        mask = (xlen >= XLEN_MAX) ? '1 : ((64'd1 << xlen) - 64'd1);
        sh   = b[5:0] & 6'(xlen - 1);
        sa   = a[xlen-1] ? (a | ~mask) : (a & mask);
        sb   = b[xlen-1] ? (b | ~mask) : (b & mask);
        res  = '0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_SLL:  res = a << sh;
            OP_SLT:  res[0] = $signed(sa) < $signed(sb);
            OP_SLTU: res[0] = (a & mask) < (b & mask);
            OP_XOR:  res = a ^ b;
            OP_SRL:  res = (a & mask) >> sh;
            OP_SRA:  res = $unsigned($signed(sa) >>> sh);
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            default: res = '0;
        endcase
        return res & mask;
    endfunction

endpackage

// File: rtl/exec_lane.sv
// One execute lane: IDLE/MUL/FULL handshake FSM, a one-entry output register
// and an XLEN-cycle shift-add multiplier.
module exec_lane
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd
);
    localparam int CNT_W = $clog2(XLEN);

    lane_state_e     r_state;
    lane_state_e     w_state_nxt;
    logic [XLEN-1:0] r_result;
    logic [RD_W-1:0] r_rd;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;

    logic            w_accept;
    logic            w_is_mul;
    logic [XLEN-1:0] w_alu_res;
    logic [XLEN-1:0] w_acc_nxt;

    assign w_accept  = in_valid & in_ready;
    assign w_is_mul  = (in_op == OP_MUL);
    assign w_alu_res = XLEN'(alu_compute(in_op, XLEN_MAX'(in_a), XLEN_MAX'(in_b), XLEN));
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_accept) w_state_nxt = w_is_mul ? MUL : FULL;
                MUL:  if (r_cnt == '0) w_state_nxt = FULL;
                FULL: begin
                    if (out_ready) begin
                        if (w_accept) w_state_nxt = w_is_mul ? MUL : FULL;
                        else          w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Ready is withheld during rst/flush so nothing is accepted on those edges.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready = ~rst & ~flush;
            FULL: begin
                in_ready  = ~rst & ~flush & out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_rd     <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (!flush) begin
            if (w_accept) begin
                r_rd <= in_rd;
                if (w_is_mul) begin
                    r_acc    <= '0;
                    r_mcand  <= in_a;
                    r_mplier <= in_b;
                    r_cnt    <= CNT_W'(XLEN - 1);
                end else begin
                    r_result <= w_alu_res;
                end
            end else if (r_state == MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
                if (r_cnt == '0) r_result <= w_acc_nxt;
            end
        end
    end

    assign out_result = r_result;
    assign out_rd     = r_rd;

endmodule

// File: rtl/exec_cluster.sv
// Multi-lane execute cluster: NUM_LANES independent exec_lane instances, the
// top level only slices the flat port vectors per lane.
module exec_cluster
    import exec_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = 32,
    parameter int RD_W      = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_LANES-1:0]      in_valid,
    output logic [NUM_LANES-1:0]      in_ready,
    input  logic [4*NUM_LANES-1:0]    in_op,
    input  logic [XLEN*NUM_LANES-1:0] in_a,
    input  logic [XLEN*NUM_LANES-1:0] in_b,
    input  logic [RD_W*NUM_LANES-1:0] in_rd,
    output logic [NUM_LANES-1:0]      out_valid,
    input  logic [NUM_LANES-1:0]      out_ready,
    output logic [XLEN*NUM_LANES-1:0] out_result,
    output logic [RD_W*NUM_LANES-1:0] out_rd
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        exec_lane #(
            .XLEN (XLEN),
            .RD_W (RD_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_op      (in_op[4*g +: 4]),
            .in_a       (in_a[XLEN*g +: XLEN]),
            .in_b       (in_b[XLEN*g +: XLEN]),
            .in_rd      (in_rd[RD_W*g +: RD_W]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_result (out_result[XLEN*g +: XLEN]),
            .out_rd     (out_rd[RD_W*g +: RD_W])
        );
    end

endmodule

// File: doc/exec_cluster.md
# exec_cluster

Parametrised multi-lane integer execute cluster for the superscalar core. It is the successor to the fixed dual-ALU stage. It provides NUM_LANES independent lanes, each with a valid/ready handshake on input and output. Each lane has a one-entry output register with backpressure and an iterative shift-add multiplier in addition to the single-cycle ALU ops. It sits between issue/operand-read and writeback, and carries each result's destination tag alongside it.

## Interface
- NUM_LANES, 2, number of independent execute lanes (1..8)
- XLEN, 32, datapath width; power of two, ≥ 8
- RD_W, 5, destination-register tag width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all in-flight and held results (synchronous)
- in_valid  in  NUM_LANES  per-lane issue valid
- in_ready  out  NUM_LANES  per-lane accept (combinational from lane state, out_ready, flush)
- in_op  in  4*NUM_LANES  per-lane opcode, lane i at [4i+3:4i]
- in_a, in_b  in  XLEN*NUM_LANES  per-lane operands
- in_rd  in  RD_W*NUM_LANES  per-lane destination tag
- out_valid  out  NUM_LANES  per-lane result valid (registered)
- out_ready  in  NUM_LANES  per-lane writeback accept
- out_result  out  XLEN*NUM_LANES  per-lane result (registered)
- out_rd  out  RD_W*NUM_LANES  per-lane tag (registered)

## Operation
- Opcodes are ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, MUL 1001 (low XLEN bits of a*b).
  - Any other code is a single-cycle op with result 0.
  - Shift amount is b[log2(XLEN)-1:0].
  - All arithmetic is modulo 2^XLEN.
- Lanes are fully independent. There is no cross-lane ordering or arbitration.
- Per-lane FSM has three states, IDLE, MUL, FULL:
  - IDLE: in_ready=1.
    - Accepting a single-cycle op moves to FULL.
    - Accepting MUL moves to MUL.
  - MUL: in_ready=0.
    - On entry, acc=0, mcand=a, mplier=b, cnt=XLEN-1, and in_rd is captured.
    - Each cycle: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1.
    - On the cycle with cnt==0, the final acc goes to out_result, and the state moves to FULL.
  - FULL: out_valid=1, in_ready=out_ready.
    - out_ready=1 with no accept moves to IDLE.
    - out_ready=1 plus a single-cycle accept stays FULL with the new result.
    - out_ready=1 plus a MUL accept moves to MUL.
    - out_ready=0 holds the result, rd and valid stable.
- A transfer occurs only when valid and ready are both high on the same edge.
- flush has priority over everything but rst.
  - All lanes go to IDLE and out_valid clears next edge.
  - in_ready=0 during the flush cycle, so no accept occurs.
  - A MUL in progress is abandoned.
- rst behaves the same as flush, and also zeroes out_result, out_rd and all iteration state.

## Timing
- Reset values: out_valid=0, out_result=0, out_rd=0, all lanes IDLE. in_ready is all ones in the first cycle after reset if flush=0.
- Single-cycle op: accepted at edge T, out_valid and result visible after edge T. Latency 1, throughput 1 per lane when out_ready is held high.
- MUL: accepted at edge T, out_valid rises after edge T+XLEN. The lane accepts nothing in between. Throughput is one MUL per XLEN+1 cycles under continuous out_ready.
- out_valid, out_result and out_rd are never combinationally dependent on inputs.
- An output stalled by out_ready=0 holds indefinitely with no value change.

## Structure
- Package exec_pkg holds:
  - opcode localparams;
  - the lane state enum (IDLE/MUL/FULL);
  - function alu_compute(op, a, b), parametrised by XLEN via the package parameter or function width argument.
- Sub-module exec_lane (one FSM, one output register, one iterative multiplier) is instantiated NUM_LANES times in a generate loop. The top level only slices the vectors.

## Test plan
- Lane0 ADD 5+7 (rd 3) and lane1 SUB 5-7 (rd 4) accepted on the same edge with out_ready=11 -> next cycle out_valid=11, results 12 and 0xFFFFFFFE, rd 3 and 4.
- Lane0 MUL 0x0001_0003 * 0x0000_0010, XLEN=32 -> in_ready[0]=0 for 32 cycles, out_valid[0] rises exactly 32 cycles after accept with 0x0010_0030. Lane1 meanwhile streams 32 ADDs, one per cycle.
- Lane0 result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready[0]=0, result/rd unchanged. out_ready=1 with an SRA 0x8000_0000>>4 pending -> next result 0xF800_0000, out_valid stays 1.
- flush asserted mid-MUL (cycle 10) on lane0 while lane1 holds a valid result -> both out_valid 0 next edge. No accept in the flush cycle. A new ADD is accepted the following cycle.
- SLT/SLTU with a=0xFFFF_FFFF, b=1 -> 1 and 0. Opcode 1111 -> 0. SLL by b=33 (shift 1) -> a<<1.
- Build with NUM_LANES=4, XLEN=16 and random ops and backpressure -> every result matches the reference model in order per lane. No result is lost or duplicated.
